// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, diff = a - b, one bit per clock.
//
// A start accepted in IDLE captures both operands; the FSM then spends exactly
// WIDTH cycles in SHIFT, resolving one bit per edge LSB first, and reports the
// result with a single-cycle done pulse from DONE before returning to IDLE.
// One operation therefore occupies WIDTH+2 cycles from accept to next accept.
//
// Optional build macro:
//   SERIAL_SUB_SAT_EN - a result that borrows out loads diff = 0 (unsigned
//                       saturation) instead of the wrapped value; borrow
//                       still reports 1. Ports and timing are unchanged.

module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // Counter holds 0..WIDTH, so it never wraps inside an operation.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // acc starts as the minuend; each shift drops the consumed LSB off the
    // bottom and inserts the new difference bit at the top, so after WIDTH
    // shifts it holds the complete difference.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sub_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] diff_nxt;
    logic             accept;
    logic             finish;

    // Full-subtractor slice for the current bit plus completion detection.
    always_comb begin
        a0       = acc[0];
        b0       = sub_sh[0];
        d_bit    = a0 ^ b0 ^ br;
        br_nxt   = (~a0 & b0) | (~(a0 ^ b0) & br);
        acc_nxt  = {d_bit, acc[WIDTH-1:1]};
        accept   = (state == IDLE) && start;
        finish   = (state == SHIFT) && (cnt == LAST_BIT);
`ifdef SERIAL_SUB_SAT_EN
        diff_nxt = br_nxt ? '0 : acc_nxt;
`else
        diff_nxt = acc_nxt;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking (<=) so every flop samples the
        // pre-edge values; blocking here would create order-dependent races.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST_BIT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: all datapath state is cleared on reset, not just the FSM,
            // so an aborted operation leaves nothing behind for the next one.
            acc    <= '0;
            sub_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            if (accept) begin
                acc    <= a;
                sub_sh <= b;
                br     <= 1'b0;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                acc    <= acc_nxt;
                sub_sh <= {1'b0, sub_sh[WIDTH-1:1]};
                br     <= br_nxt;
                cnt    <= cnt + 1'b1;
            end
            // Results change only on the last shift edge and hold otherwise.
            if (finish) begin
                diff   <= diff_nxt;
                borrow <= br_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed-vector bench for serial_sub (WIDTH = 8).
// Stimulus pushes hand-computed results into a queue; a negedge monitor pops
// and compares on every done pulse and checks diff/borrow hold while busy.

module tb_serial_sub;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] diff_wrap;
        logic [WIDTH-1:0] diff_sat;
        logic             borrow;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int checks;
    int errors;
    int done_count;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] held_diff;
    logic             held_borrow;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t pick(input vec_t v);
        exp_t e;
`ifdef SERIAL_SUB_SAT_EN
        e.diff = v.diff_sat;
`else
        e.diff = v.diff_wrap;
`endif
        e.borrow = v.borrow;
        return e;
    endfunction

    // Monitor: score each done pulse, and check results hold while busy.
    always @(negedge clk) begin
        if (done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff", 32'(diff), 32'(e.diff));
                check("borrow", 32'(borrow), 32'(e.borrow));
                held_diff   = e.diff;
                held_borrow = e.borrow;
            end
        end else if (busy) begin
            check("diff_hold", 32'(diff), 32'(held_diff));
            check("borrow_hold", 32'(borrow), 32'(held_borrow));
        end
    end

    // Launch one operation from IDLE and follow it through to IDLE again.
    task automatic run_op(input vec_t v);
        int busy_cnt;
        @(negedge clk);
        a     = v.a;
        b     = v.b;
        start = 1'b1;
        exp_q.push_back(pick(v));
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int d0;
        int dcyc[$];
        int prev_done;
        int consec;

        checks      = 0;
        errors      = 0;
        done_count  = 0;
        held_diff   = '0;
        held_borrow = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{8'd5,   8'd3,   8'h02, 8'h02, 1'b0};
        vecs[1] = '{8'd3,   8'd5,   8'hFE, 8'h00, 1'b1};
        vecs[2] = '{8'h00,  8'h00,  8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'hFF,  8'hFF,  8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h00,  8'h01,  8'hFF, 8'h00, 1'b1};
        vecs[5] = '{8'hFF,  8'h00,  8'hFF, 8'hFF, 1'b0};
        vecs[6] = '{8'hA5,  8'h5A,  8'h4B, 8'h4B, 1'b0};
        vecs[7] = '{8'h80,  8'h81,  8'hFF, 8'h00, 1'b1};

        // Reset state, with start asserted to show reset overrides it.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        start = 1'b0;
        rst   = 1'b0;

        // Directed vectors including boundaries.
        foreach (vecs[i]) run_op(vecs[i]);

        // Start re-pulsed and operands changed mid-SHIFT: one done, 9-4.
        d0 = done_count;
        @(negedge clk);
        a     = 8'd9;
        b     = 8'd4;
        start = 1'b1;
        exp_q.push_back('{8'd5, 1'b0});
        @(negedge clk);
        start = 1'b0;
        a     = 8'd1;
        b     = 8'd7;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        check("ignore_start_done", 32'(done), 32'd1);
        repeat (12) @(negedge clk);
        check("ignore_start_count", 32'(done_count - d0), 32'd1);

        // Reset 4 cycles into SHIFT aborts without a done pulse.
        d0 = done_count;
        @(negedge clk);
        a     = 8'd50;
        b     = 8'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        held_diff   = '0;
        held_borrow = 1'b0;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_count - d0), 32'd0);
        run_op('{8'd200, 8'd100, 8'd100, 8'd100, 1'b0});

        // Back-to-back with start held: three operations, WIDTH+2 apart.
        @(negedge clk);
        a     = 8'd100;
        b     = 8'd30;
        start = 1'b1;
        repeat (3) exp_q.push_back('{8'd70, 1'b0});
        prev_done = 0;
        consec    = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done) begin
                dcyc.push_back(cyc);
                if (prev_done != 0) consec++;
            end
            prev_done = int'(done);
            if (cyc == 25) start = 1'b0;
        end
        check("b2b_count", 32'(dcyc.size()), 32'd3);
        if (dcyc.size() == 3) begin
            check("b2b_first", 32'(dcyc[0]), 32'(WIDTH + 1));
            check("b2b_gap1", 32'(dcyc[1] - dcyc[0]), 32'(WIDTH + 2));
            check("b2b_gap2", 32'(dcyc[2] - dcyc[1]), 32'(WIDTH + 2));
        end
        check("b2b_pulse_width", 32'(consec), 32'd0);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, setting the operand and result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend, unsigned; captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, unsigned; captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while in SHIFT.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking a new valid result.
REQ-009 SHALL have port diff  output  WIDTH  registered result, a-b modulo 2^WIDTH.
REQ-010 SHALL have port borrow  output  1  registered final borrow-out; 1 iff a<b.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 at edge k: SHALL capture a and b into shift registers, clear the internal borrow bit and bit counter, and enter SHIFT.
REQ-013 SHIFT: each edge SHALL process one bit, LSB first: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br); d shifts into the result MSB; operand registers shift right.
REQ-014 SHALL stay in SHIFT for exactly WIDTH edges (k+1..k+WIDTH); at edge k+WIDTH SHALL load diff and borrow from the completed computation and enter DONE.
REQ-015 DONE: done=1 for exactly one cycle; SHALL return to IDLE unconditionally on the next edge.
REQ-016 Latency: done SHALL be high in the cycle after edge k+WIDTH; earliest next accepted start SHALL be at edge k+WIDTH+2.
REQ-017 start in SHIFT or DONE SHALL be ignored, with no effect on the in-flight operation.
REQ-018 a and b changing after edge k SHALL NOT affect the result.
REQ-019 diff and borrow SHALL hold their previous values during SHIFT and update only at DONE entry; they hold until the next completion or reset.
REQ-020 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap during an operation.
REQ-021 Equal operands SHALL give diff=0, borrow=0; a<b SHALL give diff=2^WIDTH+a-b, borrow=1.

Reset
REQ-022 rst=1 at any edge SHALL force state IDLE, busy=0, done=0, diff=0, borrow=0, and clear all internal registers; this overrides start.
REQ-023 rst asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-024 Macro SERIAL_SUB_SAT_EN: when defined, a completion with final borrow=1 SHALL load diff=0 (unsigned saturating); borrow SHALL still report 1.
REQ-025 Without SERIAL_SUB_SAT_EN: diff SHALL be the wrapped modulo-2^WIDTH result per REQ-021; port list and timing SHALL be identical in both builds.

Verification (WIDTH=8)
REQ-026 a=5, b=3, start for 1 cycle -> busy high 8 cycles, then done pulse 1 cycle; diff=2, borrow=0.
REQ-027 a=3, b=5 -> diff=0xFE, borrow=1; with SERIAL_SUB_SAT_EN, diff=0x00, borrow=1.
REQ-028 Boundaries a=0,b=0 -> 0/0; a=0xFF,b=0xFF -> 0/0; a=0,b=1 -> 0xFF/1 (0x00/1 with SAT); a=0xFF,b=0 -> 0xFF/0.
REQ-029 a=9, b=4, start; start pulsed and a,b changed to 1,7 during SHIFT -> single done; diff=5, borrow=0; prior diff held during SHIFT.
REQ-030 rst asserted 4 cycles into SHIFT -> no done; busy=0, diff=0 and borrow=0 next cycle; subsequent a=200, b=100 -> diff=100, borrow=0.
REQ-031 Back-to-back: start held high continuously -> operations complete every WIDTH+2 cycles; each done pulse is exactly 1 cycle wide.
